game_countdown_timer: RTL and testbench
=======================================

// Module: game_countdown_timer
// PURPOSE
//   Round countdown timer for the game. Consumes the one-cycle 100 ms tick pulse
//   from the tick generator and counts a round time down in BCD (tens.ones.tenths
//   of seconds) for the display stage. Supports start/restart and pause.
//   Emits a one-cycle timeout pulse to the game FSM when the count reaches 00.0.
// PARAMETERS
//   START_SEC   30  round length in whole seconds; legal range 0..99
// PORTS
//   clk         in   1  system clock
//   rst         in   1  asynchronous, active-high reset
//   tick_100ms  in   1  one-clk-cycle pulse every 100 ms, synchronous to clk
//   start       in   1  one-cycle pulse: load START_SEC.0 and begin counting
//   pause       in   1  level: while high, counting is frozen
//   sec_tens    out  4  BCD tens-of-seconds digit
//   sec_ones    out  4  BCD ones-of-seconds digit
//   tenths      out  4  BCD tenths-of-second digit
//   running     out  1  high while state == RUN
//   timeout     out  1  one-cycle pulse when count reaches 00.0
//   state       out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
// BEHAVIOUR
//   - Reset (async, any time, including mid-run): state=IDLE, digits=START_SEC.0
//     (tens=START_SEC/10, ones=START_SEC%10, tenths=0), running=0, timeout=0.
//   - All outputs registered; updates are visible the cycle after the causing edge.
//   - IDLE: tick ignored. start -> RUN, digits reloaded to START_SEC.0.
//   - RUN: on tick (and no start), decrement the 3-digit BCD value by one tenth:
//     tenths 0 -> 9 with borrow into ones; ones 0 -> 9 with borrow into tens.
//     Digits never leave 0..9. If the decrement yields 00.0 -> DONE.
//     pause high (and no start) -> PAUSED; a tick in that same cycle is ignored.
//   - PAUSED: ticks ignored, digits held. pause low -> RUN. start -> RUN + reload.
//   - DONE: digits held at 00.0, ticks ignored. start -> RUN + reload.
//   - timeout: high for exactly the first cycle in which state reads DONE.
//   - start has priority over tick and pause in every state; start while in
//     RUN restarts the round (reload); a coincident tick is dropped.
//   - start with pause held: enter RUN, reload, then PAUSED on the next cycle.
//   - START_SEC=0: start -> DONE directly, digits 00.0, timeout pulses once.
//   - running = (state==RUN); also registered, never glitches.
//   - One tick = one decrement; no tick accumulation while paused.
// TESTING
//   1 Reset: rst=1 mid-count (value 12.3, RUN) -> same cycle state=IDLE,
//     digits=30.0, timeout=0, running=0.
//   2 START_SEC=2: start, then 20 ticks -> 1.9 after first tick, 1.0, 0.9 borrow
//     ok, 00.0 after 20th; state=DONE and timeout=1 for one cycle only.
//   3 Borrow chain: START_SEC=10, start, 1 tick -> digits 09.9 (tens 1->0,
//     ones 0->9, tenths 0->9).
//   4 Pause: RUN at 25.0, pause=1 and 5 ticks -> stays 25.0, state=PAUSED;
//     pause=0, 1 tick -> 24.9, state=RUN.
//   5 Priority: in RUN at 07.4 assert start and tick same cycle -> 30.0, RUN,
//     no decrement; start in DONE -> 30.0, RUN, no second timeout.
//   6 START_SEC=0: start -> DONE, 00.0, exactly one timeout pulse; ticks in
//     IDLE/DONE leave digits unchanged.

Source files
------------

// File: rtl/game_countdown_timer.sv
// game_countdown_timer
//   Round countdown timer. Counts START_SEC.0 down to 00.0 in BCD
//   (tens.ones.tenths of seconds), one tenth per tick_100ms pulse. It
//   supports start/restart and a pause level, and pulses timeout once
//   when the round expires.
//
//   Ports:
//     clk          system clock
//     rst          asynchronous, active-high reset
//     tick_100ms   one-cycle pulse every 100 ms, synchronous to clk
//     start        one-cycle pulse: reload START_SEC.0 and run
//     pause        level: freezes counting while high
//     sec_tens     BCD tens-of-seconds digit
//     sec_ones     BCD ones-of-seconds digit
//     tenths       BCD tenths-of-second digit
//     running      high while state is RUN
//     timeout      one-cycle pulse on the first cycle in DONE
//     state        00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
//
//   state  | meaning
//   -------+----------------------------------------------
//   IDLE   | after reset, digits show START_SEC.0, ticks ignored
//   RUN    | each tick removes one tenth; reaching 00.0 ends the round
//   PAUSED | digits frozen, ticks dropped until pause falls
//   DONE   | digits held at 00.0 until the next start
module game_countdown_timer #(
  parameter int START_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100ms,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] tenths,
  output logic       running,
  output logic       timeout,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_PAUSED = 2'b10;
  localparam logic [1:0] S_DONE   = 2'b11;

  localparam logic [3:0] LOAD_TENS  = 4'(START_SEC / 10);
  localparam logic [3:0] LOAD_ONES  = 4'(START_SEC % 10);
  localparam logic       ZERO_ROUND = (START_SEC == 0);

  logic [1:0] state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tenths_q, tenths_d;
  logic       running_q, running_d;
  logic       timeout_q, timeout_d;

  logic [3:0] dec_tens, dec_ones, dec_tenths;
  logic       borrow_tenths, borrow_ones, dec_zero;

  // Value minus one tenth, with BCD borrow rippling upward. The tens digit
  // saturates at 0 so that no digit can ever leave 0..9.
  always_comb begin
    borrow_tenths = (tenths_q == 4'd0);
    dec_tenths    = borrow_tenths ? 4'd9 : tenths_q - 4'd1;
    borrow_ones   = borrow_tenths && (ones_q == 4'd0);
    dec_ones      = ones_q;
    if (borrow_tenths) begin
      dec_ones = (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
    end
    dec_tens = tens_q;
    if (borrow_ones && (tens_q != 4'd0)) begin
      dec_tens = tens_q - 4'd1;
    end
    dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0) && (dec_tenths == 4'd0);
  end

  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    tenths_d = tenths_q;

    if (start) begin
      // Restart wins over tick and pause in every state. A zero-length round
      // expires immediately.
      tens_d   = LOAD_TENS;
      ones_d   = LOAD_ONES;
      tenths_d = 4'd0;
      state_d  = ZERO_ROUND ? S_DONE : S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (tick_100ms) begin
            tens_d   = dec_tens;
            ones_d   = dec_ones;
            tenths_d = dec_tenths;
            if (dec_zero) begin
              state_d = S_DONE;
            end
          end
        end
        S_PAUSED: begin
          if (!pause) begin
            state_d = S_RUN;
          end
        end
        default: begin
        end
      endcase
    end

    running_d = (state_d == S_RUN);
    timeout_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tens_q    <= LOAD_TENS;
      ones_q    <= LOAD_ONES;
      tenths_q  <= 4'd0;
      running_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      tenths_q  <= tenths_d;
      running_q <= running_d;
      timeout_q <= timeout_d;
    end
  end

  assign sec_tens = tens_q;
  assign sec_ones = ones_q;
  assign tenths   = tenths_q;
  assign running  = running_q;
  assign timeout  = timeout_q;
  assign state    = state_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// tb_game_countdown_timer
//   Four timers (START_SEC = 30, 2, 10, 0) share one set of inputs. Directed
//   scenarios compare against hand-derived constants; a random phase compares
//   every output of every instance against a tenths-count reference model.
//   Observed/expected words are packed as {state, running, timeout, tens,
//   ones, tenths} so BCD values read directly in hex.
module tb_game_countdown_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic tick = 1'b0;

  logic [3:0] tens_o   [4];
  logic [3:0] ones_o   [4];
  logic [3:0] tenths_o [4];
  logic       run_o    [4];
  logic       to_o     [4];
  logic [1:0] state_o  [4];

  int n_checks = 0;
  int n_fail   = 0;

  int ss    [4] = '{30, 2, 10, 0};
  int m_cnt [4];
  int m_st  [4];
  bit m_to  [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int SSV = (g == 0) ? 30 : (g == 1) ? 2 : (g == 2) ? 10 : 0;
    game_countdown_timer #(.START_SEC(SSV)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .tick_100ms (tick),
      .start      (start),
      .pause      (pause),
      .sec_tens   (tens_o[g]),
      .sec_ones   (ones_o[g]),
      .tenths     (tenths_o[g]),
      .running    (run_o[g]),
      .timeout    (to_o[g]),
      .state      (state_o[g])
    );
  end

  function automatic logic [15:0] obs(input int k);
    return {state_o[k], run_o[k], to_o[k], tens_o[k], ones_o[k], tenths_o[k]};
  endfunction

  // Reference: remaining time held as an integer number of tenths.
  function automatic logic [15:0] mexp(input int k);
    logic [3:0] t, o, f;
    t = 4'(m_cnt[k] / 100);
    o = 4'((m_cnt[k] / 10) % 10);
    f = 4'(m_cnt[k] % 10);
    return {2'(m_st[k]), (m_st[k] == 1), m_to[k], t, o, f};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = ss[i] * 10;
      m_st[i]  = 0;
      m_to[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input bit st, input bit ps, input bit tk);
    for (int i = 0; i < 4; i++) begin
      int prev;
      prev = m_st[i];
      if (st) begin
        m_cnt[i] = ss[i] * 10;
        m_st[i]  = (ss[i] == 0) ? 3 : 1;
      end else if (m_st[i] == 1) begin
        if (ps) m_st[i] = 2;
        else if (tk) begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) m_st[i] = 3;
        end
      end else if (m_st[i] == 2) begin
        if (!ps) m_st[i] = 1;
      end
      m_to[i] = (m_st[i] == 3) && (prev != 3);
    end
  endtask

  // One clock: inputs applied at the falling edge, outputs sampled 1 ns
  // after the rising edge.
  task automatic cyc(input bit st, input bit ps, input bit tk);
    @(negedge clk);
    start = st;
    pause = ps;
    tick  = tk;
    @(posedge clk);
    model_step(st, ps, tk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_rst [4];
    exp_rst = '{16'h0300, 16'h0020, 16'h0100, 16'h0000};
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs(i) !== exp_rst[i]) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %h want %h", i, obs(i), exp_rst[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle_ticks();
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs(0) !== 16'h0300) begin
      n_fail++;
      $display("FAIL idle_tick_30: got %h want %h", obs(0), 16'h0300);
    end
    n_checks++;
    if (obs(3) !== 16'h0000) begin
      n_fail++;
      $display("FAIL idle_tick_0: got %h want %h", obs(3), 16'h0000);
    end
  endtask

  task automatic test_zero_round();
    cyc(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs(3) !== 16'hD000) begin
      n_fail++;
      $display("FAIL zero_start: got %h want %h", obs(3), 16'hD000);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs(3) !== 16'hC000) begin
        n_fail++;
        $display("FAIL zero_hold[%0d]: got %h want %h", k, obs(3), 16'hC000);
      end
    end
  endtask

  task automatic test_count_s2();
    cyc(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs(1) !== 16'h6020) begin
      n_fail++;
      $display("FAIL s2_load: got %h want %h", obs(1), 16'h6020);
    end
    for (int k = 1; k <= 20; k++) begin
      logic [15:0] want;
      cyc(1'b0, 1'b0, 1'b1);
      case (k)
        1:       want = 16'h6019;
        10:      want = 16'h6010;
        11:      want = 16'h6009;
        19:      want = 16'h6001;
        20:      want = 16'hD000;
        default: want = obs(1);
      endcase
      if (k == 1 || k == 10 || k == 11 || k == 19 || k == 20) begin
        n_checks++;
        if (obs(1) !== want) begin
          n_fail++;
          $display("FAIL s2_tick%0d: got %h want %h", k, obs(1), want);
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs(1) !== 16'hC000) begin
      n_fail++;
      $display("FAIL s2_timeout_once: got %h want %h", obs(1), 16'hC000);
    end
  endtask

  task automatic test_borrow();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs(2) !== 16'h6099) begin
      n_fail++;
      $display("FAIL borrow_chain: got %h want %h", obs(2), 16'h6099);
    end
  endtask

  task automatic test_pause();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (50) cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs(0) !== 16'h6250) begin
      n_fail++;
      $display("FAIL pause_pre: got %h want %h", obs(0), 16'h6250);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, 1'b1);
      n_checks++;
      if (obs(0) !== 16'h8250) begin
        n_fail++;
        $display("FAIL pause_hold[%0d]: got %h want %h", k, obs(0), 16'h8250);
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs(0) !== 16'h6250) begin
      n_fail++;
      $display("FAIL pause_release: got %h want %h", obs(0), 16'h6250);
    end
    cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs(0) !== 16'h6249) begin
      n_fail++;
      $display("FAIL pause_resume_tick: got %h want %h", obs(0), 16'h6249);
    end
  endtask

  task automatic test_priority();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (226) cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs(0) !== 16'h6074) begin
      n_fail++;
      $display("FAIL prio_pre: got %h want %h", obs(0), 16'h6074);
    end
    cyc(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (obs(0) !== 16'h6300) begin
      n_fail++;
      $display("FAIL prio_start_tick: got %h want %h", obs(0), 16'h6300);
    end
    repeat (299) cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs(0) !== 16'h6001) begin
      n_fail++;
      $display("FAIL prio_last_tenth: got %h want %h", obs(0), 16'h6001);
    end
    cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs(0) !== 16'hD000) begin
      n_fail++;
      $display("FAIL prio_done: got %h want %h", obs(0), 16'hD000);
    end
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (obs(0) !== 16'h6300) begin
      n_fail++;
      $display("FAIL prio_restart_done: got %h want %h", obs(0), 16'h6300);
    end
    cyc(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs(0) !== 16'h6300) begin
      n_fail++;
      $display("FAIL prio_no_second_timeout: got %h want %h", obs(0), 16'h6300);
    end
  endtask

  task automatic test_start_with_pause();
    cyc(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (obs(0) !== 16'h6300) begin
      n_fail++;
      $display("FAIL startpause_run: got %h want %h", obs(0), 16'h6300);
    end
    cyc(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (obs(0) !== 16'h8300) begin
      n_fail++;
      $display("FAIL startpause_paused: got %h want %h", obs(0), 16'h8300);
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit ps;
    ps = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      bit st, tk;
      if ($urandom_range(0, 11) == 0) ps = ~ps;
      st = ($urandom_range(0, 59) == 0);
      tk = ($urandom_range(0, 2) != 0);
      cyc(st, ps, tk);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs(i) !== mexp(i)) begin
          n_fail++;
          $display("FAIL random[%0d] inst%0d: got %h want %h", c, i, obs(i), mexp(i));
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (177) cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs(0) !== 16'h6123) begin
      n_fail++;
      $display("FAIL midrun_pre: got %h want %h", obs(0), 16'h6123);
    end
    @(negedge clk);
    tick = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs(0) !== 16'h0300) begin
      n_fail++;
      $display("FAIL midrun_async_reset: got %h want %h", obs(0), 16'h0300);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs(0) !== 16'h0300) begin
      n_fail++;
      $display("FAIL midrun_after_reset: got %h want %h", obs(0), 16'h0300);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ticks();
    test_zero_round();
    test_count_s2();
    test_borrow();
    test_pause();
    test_priority();
    test_start_with_pause();
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
